// File: rtl/regfile_dump.sv
// Register-file debug dump: reads each register through a spare read port and
// streams a header byte followed by every register, LSB first, over valid/ready.
module regfile_dump #(
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W-1:0]   rf_ra_q, rf_ra_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                hs;

  // A byte transfers whenever valid and ready are both high at the clock edge;
  // valid and data depend only on state, so they hold steady across stalls.
  assign hs = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      rf_ra_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      rf_ra_q    <= rf_ra_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    rf_ra_d    = rf_ra_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR;
          index_d = '0;
          rf_ra_d = '0;
        end
      end
      S_HDR: begin
        if (abort)   state_d = S_IDLE;
        else if (hs) state_d = S_READ;
      end
      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          word_d     = rf_rd;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        // abort wins over a same-cycle handshake; that byte is lost
        if (abort) begin
          state_d = S_IDLE;
        end else if (hs) begin
          word_d     = word_q >> 8;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            if (index_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + 1'b1;
              rf_ra_d = index_q + 1'b1;
              state_d = S_READ;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        busy     = 1'b1;
      end
      S_READ: busy = 1'b1;
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign rf_ra = rf_ra_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: per-cycle vector table for the opening sequence,
// then scripted full dumps with back-pressure, abort, restart and reset.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, tx_ready;
  logic        busy, done, tx_valid;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic [7:0]  tx_data;

  logic [31:0] rf [32];
  assign rf_rd = rf[rf_ra];

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         done_q[$];
  int         start_cyc = 0;
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Byte/done monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        chk("stall_valid_held", {31'd0, tx_valid}, 32'd1);
        chk("stall_data_held", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready && !abort) begin
        got_q.push_back(tx_data);
        got_cyc_q.push_back(cyc - start_cyc);
      end
      if (done) done_q.push_back(cyc - start_cyc);
      prev_stall = tx_valid && !tx_ready && !abort;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- model helpers ----------------
  task automatic init_rf();
    for (int i = 0; i < 32; i++) rf[i] = 32'h01010101 * i;
  endtask

  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 32; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(rf[i][8*b +: 8]);
  endtask

  task automatic cmp_stream(string name);
    int n;
    chk({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_byte%0d: got=%h want=%h", name, i, got_q[i], exp_q[i]);
      end
      total++;
    end
  endtask

  // ---------------- driver ----------------
  // Runs one dump started in relative cycle 0; the other *_at arguments name
  // relative cycles for a second start, abort, async reset and a CPU write.
  task automatic run(input int ncyc, input int start2_at, input int abort_at,
                     input int rst_at, input int wr_at, input bit rnd,
                     input bit stop_on_done);
    got_q.delete();
    got_cyc_q.delete();
    done_q.delete();
    mon_en = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      if (n == 0) start_cyc = cyc;
      start    = (n == 0) || (n == start2_at);
      abort    = (n == abort_at);
      tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (n == wr_at) rf[31] = 32'h12345678;
      if (n == rst_at + 1) rst_n = 1'b1;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_ra", {27'd0, rf_ra}, 32'd0);
      end
      if (n == abort_at + 1) begin
        @(negedge clk);
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
      end
      @(posedge clk);
      #1;
      if (stop_on_done && done_q.size() > 0) break;
    end
    start  = 1'b0;
    abort  = 1'b0;
    mon_en = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start, abort, ready;
    logic       busy, done, valid;
    logic [7:0] data;
    logic [4:0] ra;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic s, logic a, logic r, logic b, logic d,
                              logic v, logic [7:0] dt, logic [4:0] ra);
    vec_t x;
    x.start = s; x.abort = a; x.ready = r;
    x.busy = b; x.done = d; x.valid = v; x.data = dt; x.ra = ra;
    return x;
  endfunction

  // ---------------- main ----------------
  initial begin
    logic [31:0] saved;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    init_rf();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
    chk("reset_rf_ra", {27'd0, rf_ra}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //            st ab rd  bsy dn  vl  data   ra
    vecs[0]  = mk(1, 0, 0,  0,  0,  0,  8'h00, 5'd0);
    vecs[1]  = mk(0, 0, 0,  1,  0,  1,  8'hA5, 5'd0);
    vecs[2]  = mk(0, 0, 1,  1,  0,  1,  8'hA5, 5'd0);
    vecs[3]  = mk(0, 0, 1,  1,  0,  0,  8'h00, 5'd0);
    vecs[4]  = mk(0, 0, 1,  1,  0,  1,  8'h00, 5'd0);
    vecs[5]  = mk(0, 0, 1,  1,  0,  1,  8'h00, 5'd0);
    vecs[6]  = mk(0, 0, 1,  1,  0,  1,  8'h00, 5'd0);
    vecs[7]  = mk(0, 0, 1,  1,  0,  1,  8'h00, 5'd0);
    vecs[8]  = mk(0, 0, 0,  1,  0,  0,  8'h00, 5'd1);
    vecs[9]  = mk(0, 0, 0,  1,  0,  1,  8'h01, 5'd1);
    vecs[10] = mk(0, 0, 1,  1,  0,  1,  8'h01, 5'd1);
    vecs[11] = mk(0, 0, 1,  1,  0,  1,  8'h01, 5'd1);
    vecs[12] = mk(0, 1, 1,  1,  0,  1,  8'h01, 5'd1);
    vecs[13] = mk(0, 0, 0,  0,  0,  0,  8'h00, 5'd1);
    vecs[14] = mk(1, 1, 0,  0,  0,  0,  8'h00, 5'd1);
    vecs[15] = mk(0, 0, 0,  1,  0,  1,  8'hA5, 5'd0);
    vecs[16] = mk(0, 1, 0,  1,  0,  1,  8'hA5, 5'd0);
    vecs[17] = mk(0, 0, 0,  0,  0,  0,  8'h00, 5'd0);
    vecs[18] = mk(0, 1, 0,  0,  0,  0,  8'h00, 5'd0);
    vecs[19] = mk(0, 0, 0,  0,  0,  0,  8'h00, 5'd0);

    for (int i = 0; i < 20; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; tx_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].done});
      chk($sformatf("vec%0d_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].data});
      chk($sformatf("vec%0d_ra", i), {27'd0, rf_ra}, {27'd0, vecs[i].ra});
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0;

    // Full dump, ready high, extra start mid-stream, CPU write to r31 during reg 3.
    init_rf();
    saved = rf[31];
    rf[31] = 32'h12345678;
    build_exp();
    rf[31] = saved;
    run(200, 64, -10, -10, 19, 1'b0, 1'b1);
    cmp_stream("full");
    chk("full_done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("full_done_cycle", done_q[0], 162);
    if (got_cyc_q.size() > 0) chk("full_hdr_cycle", got_cyc_q[0], 1);
    if (got_cyc_q.size() == 129) chk("full_last_byte_cycle", got_cyc_q[128], 161);
    chk("full_idle_busy", {31'd0, busy}, 32'd0);
    chk("full_idle_valid", {31'd0, tx_valid}, 32'd0);

    // Back-pressure at ~30% ready duty.
    init_rf();
    rf[5] = 32'hDEADBEEF;
    build_exp();
    run(3000, -10, -10, -10, -10, 1'b1, 1'b1);
    cmp_stream("bp");
    chk("bp_done_count", done_q.size(), 1);
    if (got_q.size() >= 25)
      chk("bp_reg5", {got_q[24], got_q[23], got_q[22], got_q[21]}, 32'hDEADBEEF);

    // Abort during byte 2 of register 10 (relative cycle 55).
    init_rf();
    build_exp();
    while (exp_q.size() > 43) void'(exp_q.pop_back());
    run(80, -10, 55, -10, -10, 1'b0, 1'b0);
    cmp_stream("abort");
    chk("abort_no_done", done_q.size(), 0);

    // Restart after abort begins from the header.
    build_exp();
    run(200, -10, -10, -10, -10, 1'b0, 1'b1);
    cmp_stream("restart");
    chk("restart_done_count", done_q.size(), 1);

    // Async reset during SEND of register 7, then a fresh dump.
    run(45, -10, -10, 39, -10, 1'b0, 1'b0);
    rst_n = 1'b1;
    build_exp();
    run(200, -10, -10, -10, -10, 1'b0, 1'b1);
    cmp_stream("post_reset");
    if (done_q.size() > 0) chk("post_reset_done_cycle", done_q[0], 162);
    else chk("post_reset_done_seen", done_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
